// File: rtl/inst_seq_ctrl.sv
// Program sequencer for the HDC encoder instruction path: PC generation,
// two nested hardware loops and operand/AM stall handling.
module inst_seq_ctrl #(
  parameter  int InstMemDepth = 64,
  parameter  int LoopCntWidth = 10,
  localparam int PcWidth      = $clog2(InstMemDepth)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [PcWidth-1:0]      last_addr_i,
  input  logic [1:0]              loop_en_i,
  input  logic [PcWidth-1:0]      loop0_start_i,
  input  logic [PcWidth-1:0]      loop0_end_i,
  input  logic [LoopCntWidth-1:0] loop0_count_i,
  input  logic [PcWidth-1:0]      loop1_start_i,
  input  logic [PcWidth-1:0]      loop1_end_i,
  input  logic [LoopCntWidth-1:0] loop1_count_i,
  input  logic                    im_a_req_i,
  input  logic                    im_b_req_i,
  input  logic                    im_a_valid_i,
  input  logic                    im_b_valid_i,
  input  logic                    am_busy_i,
  output logic [PcWidth-1:0]      pc_o,
  output logic                    inst_en_o,
  output logic                    stall_o,
  output logic                    busy_o,
  output logic                    done_o
);

  // state | meaning
  // IDLE  | waiting for start_i, pc parked at 0
  // RUN   | issuing one instruction per unstalled cycle
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [PcWidth-1:0]      pc_q, pc_d, pc_inc;
  logic [LoopCntWidth-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                    done_q, done_d;

  logic [PcWidth-1:0]      last_q, l0_start_q, l0_end_q, l1_start_q, l1_end_q;
  logic [1:0]              loop_en_q;
  logic [LoopCntWidth-1:0] l0_count_q, l1_count_q;
  logic [LoopCntWidth-1:0] l0_final, l1_final;

  logic run, stall, l0_hit, l1_hit;

  assign run       = (state_q == RUN);
  assign stall     = am_busy_i | (im_a_req_i & ~im_a_valid_i) | (im_b_req_i & ~im_b_valid_i);
  assign inst_en_o = run & ~stall;
  assign stall_o   = run & stall;
  assign busy_o    = run;
  assign done_o    = done_q;
  assign pc_o      = pc_q;

  // A programmed count of 0 still means one pass through the body.
  assign l0_final = (l0_count_q == '0) ? '0 : l0_count_q - LoopCntWidth'(1);
  assign l1_final = (l1_count_q == '0) ? '0 : l1_count_q - LoopCntWidth'(1);
  assign l0_hit   = loop_en_q[0] && (pc_q == l0_end_q);
  assign l1_hit   = loop_en_q[1] && (pc_q == l1_end_q);
  assign pc_inc   = (pc_q == PcWidth'(InstMemDepth - 1)) ? '0 : pc_q + PcWidth'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        pc_d    = '0;
        cnt0_d  = '0;
        cnt1_d  = '0;
      end
    end else if (stop_i) begin
      state_d = IDLE;
      pc_d    = '0;
      cnt0_d  = '0;
      cnt1_d  = '0;
    end else if (inst_en_o) begin
      // Loop jumps take precedence over last_addr so a loop may end on it.
      if (l0_hit && (cnt0_q < l0_final)) begin
        pc_d   = l0_start_q;
        cnt0_d = cnt0_q + LoopCntWidth'(1);
      end else begin
        if (l0_hit) cnt0_d = '0;
        if (l1_hit && (cnt1_q < l1_final)) begin
          pc_d   = l1_start_q;
          cnt1_d = cnt1_q + LoopCntWidth'(1);
        end else begin
          if (l1_hit) cnt1_d = '0;
          if (pc_q == last_q) begin
            state_d = IDLE;
            pc_d    = '0;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q     <= '0;
      loop_en_q  <= '0;
      l0_start_q <= '0;
      l0_end_q   <= '0;
      l0_count_q <= '0;
      l1_start_q <= '0;
      l1_end_q   <= '0;
      l1_count_q <= '0;
    end else if ((state_q == IDLE) && start_i) begin
      last_q     <= last_addr_i;
      loop_en_q  <= loop_en_i;
      l0_start_q <= loop0_start_i;
      l0_end_q   <= loop0_end_i;
      l0_count_q <= loop0_count_i;
      l1_start_q <= loop1_start_i;
      l1_end_q   <= loop1_end_i;
      l1_count_q <= loop1_count_i;
    end
  end

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Self-checking bench for inst_seq_ctrl: table of loop programs with expected
// issue sequences, plus hand-written stall, stop, reset and start cases.
module tb_inst_seq_ctrl;
  localparam int PW = 6;
  localparam int CW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni, start_i, stop_i;
  logic [PW-1:0] last_addr_i, loop0_start_i, loop0_end_i, loop1_start_i, loop1_end_i;
  logic [1:0]    loop_en_i;
  logic [CW-1:0] loop0_count_i, loop1_count_i;
  logic          im_a_req_i, im_b_req_i, im_a_valid_i, im_b_valid_i, am_busy_i;
  logic [PW-1:0] pc_o;
  logic          inst_en_o, stall_o, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  inst_seq_ctrl #(.InstMemDepth(64), .LoopCntWidth(10)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .last_addr_i(last_addr_i), .loop_en_i(loop_en_i),
    .loop0_start_i(loop0_start_i), .loop0_end_i(loop0_end_i), .loop0_count_i(loop0_count_i),
    .loop1_start_i(loop1_start_i), .loop1_end_i(loop1_end_i), .loop1_count_i(loop1_count_i),
    .im_a_req_i(im_a_req_i), .im_b_req_i(im_b_req_i),
    .im_a_valid_i(im_a_valid_i), .im_b_valid_i(im_b_valid_i), .am_busy_i(am_busy_i),
    .pc_o(pc_o), .inst_en_o(inst_en_o), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o)
  );

  // seq holds the expected issued pcs as hex digits, first issue in the lowest nibble.
  typedef struct {
    logic [PW-1:0] last;
    logic [1:0]    en;
    logic [PW-1:0] s0, e0;
    logic [CW-1:0] c0;
    logic [PW-1:0] s1, e1;
    logic [CW-1:0] c1;
    int            n;
    logic [63:0]   seq;
  } vec_t;

  vec_t          vecs[6];
  logic [PW-1:0] exp_q[$];
  int            compared = 0;
  int            mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_prog(input vec_t v, input bit with_stop);
    @(negedge clk_i);
    last_addr_i   = v.last;  loop_en_i     = v.en;
    loop0_start_i = v.s0;    loop0_end_i   = v.e0;  loop0_count_i = v.c0;
    loop1_start_i = v.s1;    loop1_end_i   = v.e1;  loop1_count_i = v.c1;
    start_i = 1'b1;
    stop_i  = with_stop;
    @(negedge clk_i);
    start_i = 1'b0;
    stop_i  = 1'b0;
    // Configuration must have been latched; scramble the live inputs.
    last_addr_i   = PW'($urandom);  loop_en_i     = 2'($urandom);
    loop0_start_i = PW'($urandom);  loop0_end_i   = PW'($urandom);
    loop0_count_i = CW'($urandom);  loop1_start_i = PW'($urandom);
    loop1_end_i   = PW'($urandom);  loop1_count_i = CW'($urandom);
  endtask

  task automatic run_prog(input vec_t v, input int stall_pc, input int stall_kind,
                          input bit pulse_start, input bit with_stop);
    int  dones   = 0;
    int  issued  = 0;
    bit  stalled = 1'b0;
    for (int i = 0; i < v.n; i++)
      exp_q.push_back((v.n > 16) ? PW'(i) : PW'(v.seq[4*i +: 4]));
    start_prog(v, with_stop);
    for (int guard = 0; guard < 400; guard++) begin
      if (!stalled && stall_pc >= 0 && busy_o && int'(pc_o) == stall_pc) begin
        stalled = 1'b1;
        case (stall_kind)
          0: begin im_a_req_i = 1'b1; im_a_valid_i = 1'b0; end
          1: am_busy_i = 1'b1;
          default: begin im_b_req_i = 1'b1; im_b_valid_i = 1'b0; end
        endcase
        for (int k = 0; k < 3; k++) begin
          #1;
          check("stall_inst_en", inst_en_o, 0);
          check("stall_o", stall_o, 1);
          check("stall_pc_hold", pc_o, stall_pc);
          @(negedge clk_i);
        end
        im_a_valid_i = 1'b1;
        im_b_valid_i = 1'b1;
        am_busy_i    = 1'b0;
        #1;
      end
      start_i = pulse_start && (issued == 2);
      if (inst_en_o) begin
        if (exp_q.size() == 0) check("extra_issue", pc_o, 32'hFFFF_FFFF);
        else check("issue_pc", pc_o, exp_q.pop_front());
        issued++;
      end
      if (done_o) begin
        dones++;
        check("done_no_issue", inst_en_o, 0);
        check("busy_at_done", busy_o, 0);
        break;
      end
      @(negedge clk_i);
      im_a_req_i = 1'b0;
      im_b_req_i = 1'b0;
    end
    start_i = 1'b0;
    check("done_count", dones, 1);
    check("issues_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_i);
    check("done_one_cycle", done_o, 0);
    check("idle_pc", pc_o, 0);
  endtask

  initial begin
    vec_t v;
    int   guard;
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   issued;
    vecs[0] = '{last:3, en:2'b00, s0:0, e0:0, c0:0, s1:0, e1:0, c1:0, n:4, seq:64'h3210};
    vecs[1] = '{last:3, en:2'b01, s0:1, e0:2, c0:3, s1:0, e1:0, c1:0, n:8, seq:64'h32121210};
    vecs[2] = '{last:2, en:2'b11, s0:1, e0:1, c0:2, s1:0, e1:2, c1:2, n:8, seq:64'h21102110};
    vecs[3] = '{last:3, en:2'b01, s0:1, e0:2, c0:0, s1:0, e1:0, c1:0, n:4, seq:64'h3210};
    vecs[4] = '{last:3, en:2'b01, s0:2, e0:3, c0:2, s1:0, e1:0, c1:0, n:6, seq:64'h323210};
    vecs[5] = '{last:1, en:2'b10, s0:0, e0:0, c0:0, s1:0, e1:1, c1:3, n:6, seq:64'h101010};

    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    last_addr_i = '0; loop_en_i = '0;
    loop0_start_i = '0; loop0_end_i = '0; loop0_count_i = '0;
    loop1_start_i = '0; loop1_end_i = '0; loop1_count_i = '0;
    im_a_req_i = 1'b0; im_b_req_i = 1'b0; im_a_valid_i = 1'b1; im_b_valid_i = 1'b1;
    am_busy_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_pc", pc_o, 0);
    check("rst_inst_en", inst_en_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) run_prog(vecs[i], -1, 0, 1'b0, 1'b0);

    run_prog(vecs[0], 1, 0, 1'b0, 1'b0);   // IM A missing at pc 1
    run_prog(vecs[1], 2, 1, 1'b0, 1'b0);   // AM busy at first pc 2
    run_prog(vecs[2], 1, 2, 1'b0, 1'b0);   // IM B missing inside nested loop
    run_prog(vecs[1], -1, 0, 1'b1, 1'b0);  // start pulsed while running
    run_prog(vecs[0], -1, 0, 1'b0, 1'b1);  // start and stop together in IDLE

    v = '{last:63, en:2'b00, s0:0, e0:0, c0:0, s1:0, e1:0, c1:0, n:64, seq:64'h0};
    run_prog(v, -1, 0, 1'b0, 1'b0);

    // Abort with stop_i at pc 2.
    v = '{last:5, en:2'b00, s0:0, e0:0, c0:0, s1:0, e1:0, c1:0, n:0, seq:64'h0};
    start_prog(v, 1'b0);
    for (int g = 0; g < 20 && !(inst_en_o && pc_o == 2); g++) @(negedge clk_i);
    check("stop_reached_pc2", pc_o, 2);
    stop_i = 1'b1;
    #1;
    check("stop_cycle_issue", inst_en_o, 1);
    @(negedge clk_i);
    stop_i = 1'b0;
    check("stop_busy", busy_o, 0);
    check("stop_pc", pc_o, 0);
    check("stop_inst_en", inst_en_o, 0);
    check("stop_no_done", done_o, 0);
    @(negedge clk_i);
    check("stop_no_done_late", done_o, 0);

    // Synchronous reset in the middle of the inner loop.
    start_prog(vecs[1], 1'b0);
    issued = 0;
    for (int g = 0; g < 20 && issued < 5; g++) begin
      if (inst_en_o) issued++;
      if (issued < 5) @(negedge clk_i);
    end
    check("rst_mid_issues", issued, 5);
    rst_ni    = 1'b0;
    am_busy_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_pc", pc_o, 0);
    check("rst_mid_inst_en", inst_en_o, 0);
    check("rst_mid_stall", stall_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_done", done_o, 0);
    rst_ni    = 1'b1;
    am_busy_i = 1'b0;
    run_prog(vecs[0], -1, 0, 1'b0, 1'b0);
    run_prog(vecs[2], -1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_seq_ctrl.md
Name: inst_seq_ctrl

Overview:
- Program sequencer for the HDC encoder instruction path.
- Generates the instruction-memory read address (PC) and drives the decoder `enable_i` through `inst_en_o`.
- Supports two nested hardware loops (inner loop 0, outer loop 1) and stalls on missing IM operands or a busy AM.
- Sits between the instruction memory, the instruction decoder and the IM/AM handshakes.

Parameters:
- InstMemDepth, 64, number of instruction words; PcWidth = $clog2(InstMemDepth).
- LoopCntWidth, 10, width of loop iteration counts.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  start program (honoured only in IDLE).
- stop_i  in  1  abort running program.
- last_addr_i  in  PcWidth  address of final instruction.
- loop_en_i  in  2  bit0 enables loop0 (inner), bit1 enables loop1 (outer).
- loop0_start_i / loop0_end_i  in  PcWidth  loop0 body bounds, inclusive.
- loop0_count_i  in  LoopCntWidth  loop0 iterations.
- loop1_start_i / loop1_end_i  in  PcWidth  loop1 body bounds, inclusive.
- loop1_count_i  in  LoopCntWidth  loop1 iterations.
- im_a_req_i  in  1  current instruction pops IM A (ungated decode of `inst_code`).
- im_b_req_i  in  1  current instruction pops IM B.
- im_a_valid_i  in  1  IM A has data.
- im_b_valid_i  in  1  IM B has data.
- am_busy_i  in  1  AM search in progress.
- pc_o  out  PcWidth  instruction address.
- inst_en_o  out  1  instruction issues this cycle (to decoder `enable_i`).
- stall_o  out  1  RUN but blocked.
- busy_o  out  1  state is RUN.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE and RUN.
- Reset (rst_ni=0 at a clock edge, including mid-run): state IDLE; pc_o=0; loop counters cnt0=cnt1=0; inst_en_o=0; stall_o=0; busy_o=0; done_o=0. All configuration registers clear to 0.
- Start: on start_i=1 in IDLE, latch last_addr, loop_en and all loop bounds/counts into internal registers. Next cycle: state RUN, pc=0, counters=0. start_i is ignored in RUN.
- Configuration inputs are don't-care except in the start cycle.
- Stall: stall = am_busy_i | (im_a_req_i & ~im_a_valid_i) | (im_b_req_i & ~im_b_valid_i).
- Issue: inst_en_o = RUN & ~stall (combinational). stall_o = RUN & stall.
- While stalled, pc and counters hold.
- A count value of 0 is treated as 1 (a single pass, no jump back).
- PC update on each issue, first matching rule wins:
  1. loop0 enabled, pc==loop0_end, cnt0 < count0-1: pc <= loop0_start; cnt0++.
  2. Otherwise, if loop0 enabled and pc==loop0_end: cnt0 <= 0; continue to rule 3.
  3. loop1 enabled, pc==loop1_end, cnt1 < count1-1: pc <= loop1_start; cnt1++.
  4. Otherwise, if loop1 enabled and pc==loop1_end: cnt1 <= 0; continue to rule 5.
  5. pc==last_addr: state <= IDLE; pc <= 0; done_o=1 in the following cycle.
  6. Otherwise: pc <= pc+1, wrapping modulo InstMemDepth.
- A jump in rule 1 or 3 takes priority over last_addr, so a loop may end on the last instruction.
- Throughput: one instruction per cycle when unstalled; a jump costs no bubble.
- stop_i in RUN: next cycle IDLE, pc=0, counters=0, no done pulse. Any instruction issued in the stop cycle still completes.
- stop_i and start_i asserted together in IDLE: start wins.
- done_o is high for exactly one cycle and never coincides with inst_en_o.

Test Plan:
- Straight line: last=3, loop_en=0, no stalls, start -> pc_o 0,1,2,3 with inst_en_o=1 for 4 cycles; done_o pulses in cycle 5; busy_o falls with it.
- Inner loop: loop0 1..2 count=3, last=3 -> issued pc sequence 0,1,2,1,2,1,2,3 (8 issues); done_o once.
- Nested loops: loop0 1..1 count=2, loop1 0..2 count=2, last=2 -> 0,1,1,2,0,1,1,2; cnt0/cnt1 return to 0; done_o once.
- Stall: at pc=1, im_a_req_i=1 with im_a_valid_i=0 for 3 cycles, then 1 -> pc_o holds 1, inst_en_o=0 and stall_o=1 for 3 cycles, then issue; am_busy_i=1 produces the same behaviour.
- Abort and reset: stop_i at pc=2 -> IDLE next cycle, pc_o=0, no done_o. Repeat with rst_ni=0 mid-loop -> all outputs 0 next cycle. A subsequent start runs normally from pc 0.
- Edge cases: count=0 behaves as one pass. last=InstMemDepth-1 completes without wrapping. start_i pulsed during RUN has no effect.
